// File: rtl/factorial_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : factorial_pkg
//  Description : Shared types and default widths for the iterative factorial
//                engine (factorial_unit and its multiplier fact_mul).
//                  fact_state_t : FSM state encoding {IDLE, MUL, DONE}
//                  FACT_N_W     : default operand/counter width
//                  FACT_RES_W   : default accumulator/result width
//  Revision    : 1.0 - initial release
// ============================================================================
package factorial_pkg;

  localparam int FACT_N_W   = 4;
  localparam int FACT_RES_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DONE = 2'd2
  } fact_state_t;

endpackage : factorial_pkg
`default_nettype wire

// File: rtl/fact_mul.sv
`default_nettype none
// ============================================================================
//  Module      : fact_mul
//  Description : Combinational RES_W x N_W multiplier for the factorial engine.
//                Returns the product truncated to RES_W bits and, when the
//                overflow feature is built (FACTORIAL_OVERFLOW_EN), a flag
//                that is set whenever the upper N_W product bits are non-zero.
//  Ports       : i_a       in  RES_W  accumulator operand
//                i_b       in  N_W    counter operand
//                o_prod_lo out RES_W  low RES_W bits of i_a * i_b
//                o_hi_nz   out 1      upper N_W product bits non-zero
//                                     (present only with FACTORIAL_OVERFLOW_EN)
//  Revision    : 1.0 - initial release
// ============================================================================
module fact_mul
  import factorial_pkg::*;
#(
  parameter int RES_W = FACT_RES_W,
  parameter int N_W   = FACT_N_W
) (
  input  logic [RES_W-1:0] i_a,
  input  logic [N_W-1:0]   i_b,
  output logic [RES_W-1:0] o_prod_lo
`ifdef FACTORIAL_OVERFLOW_EN
  ,
  output logic             o_hi_nz
`endif
);

`ifdef FACTORIAL_OVERFLOW_EN
  localparam int c_PROD_W = RES_W + N_W;

  logic [c_PROD_W-1:0] w_a_ext;
  logic [c_PROD_W-1:0] w_b_ext;
  logic [c_PROD_W-1:0] w_prod;

  assign w_a_ext   = c_PROD_W'(i_a);
  assign w_b_ext   = c_PROD_W'(i_b);
  assign w_prod    = w_a_ext * w_b_ext;
  assign o_prod_lo = w_prod[RES_W-1:0];
  assign o_hi_nz   = |w_prod[c_PROD_W-1:RES_W];
`else
  // Only the low half is ever consumed, so build just a RES_W-wide multiply.
  logic [RES_W-1:0] w_b_ext;

  assign w_b_ext   = RES_W'(i_b);
  assign o_prod_lo = i_a * w_b_ext;
`endif

endmodule : fact_mul
`default_nettype wire

// File: rtl/factorial_unit.sv
`default_nettype none
// ============================================================================
//  Module      : factorial_unit
//  Description : Iterative factorial engine. Captures n on a start handshake,
//                multiplies an accumulator by a decrementing counter until the
//                counter reaches 1, then publishes n! with a one-cycle done.
//                Optional overflow detection / saturation is built when the
//                macro FACTORIAL_OVERFLOW_EN is defined; otherwise the result
//                is the truncated low RES_W bits and overflow is tied to 0.
//  Ports       : clock       in  1      system clock, rising edge
//                reset_n     in  1      asynchronous active-low reset
//                start       in  1      request, sampled only in IDLE
//                abort       in  1      cancel, effective only in MUL
//                operand     in  N_W    n, captured when start is accepted
//                busy        out 1      high while in MUL
//                done        out 1      one-cycle pulse when result updates
//                result      out RES_W  last completed n!
//                overflow    out 1      overflow flag of last completed result
//                counter_out out N_W    live counter value (debug)
//  Revision    : 1.0 - initial release
// ============================================================================
module factorial_unit
  import factorial_pkg::*;
#(
  parameter int N_W   = FACT_N_W,
  parameter int RES_W = FACT_RES_W
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             start,
  input  logic             abort,
  input  logic [N_W-1:0]   operand,
  output logic             busy,
  output logic             done,
  output logic [RES_W-1:0] result,
  output logic             overflow,
  output logic [N_W-1:0]   counter_out
);

  fact_state_t      state_q,   state_d;
  logic [N_W-1:0]   counter_q, counter_d;
  logic [RES_W-1:0] acc_q,     acc_d;
  logic [RES_W-1:0] result_q,  result_d;
  logic             done_q,    done_d;
  logic [RES_W-1:0] w_prod_lo;

`ifdef FACTORIAL_OVERFLOW_EN
  logic             ovf_q,      ovf_d;
  logic             overflow_q, overflow_d;
  logic             w_prod_hi_nz;
`endif

  // --------------------------------------------------------------------------
  // Datapath multiplier: accumulator x counter
  // --------------------------------------------------------------------------
  fact_mul #(
    .RES_W (RES_W),
    .N_W   (N_W)
  ) u_fact_mul (
    .i_a       (acc_q),
    .i_b       (counter_q),
    .o_prod_lo (w_prod_lo)
`ifdef FACTORIAL_OVERFLOW_EN
    ,
    .o_hi_nz   (w_prod_hi_nz)
`endif
  );

  // --------------------------------------------------------------------------
  // State / datapath registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      counter_q  <= '0;
      acc_q      <= RES_W'(1);
      result_q   <= '0;
      done_q     <= 1'b0;
`ifdef FACTORIAL_OVERFLOW_EN
      ovf_q      <= 1'b0;
      overflow_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      counter_q  <= counter_d;
      acc_q      <= acc_d;
      result_q   <= result_d;
      done_q     <= done_d;
`ifdef FACTORIAL_OVERFLOW_EN
      ovf_q      <= ovf_d;
      overflow_q <= overflow_d;
`endif
    end
  end

  // --------------------------------------------------------------------------
  // Next-state and datapath control
  // --------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    counter_d  = counter_q;
    acc_d      = acc_q;
    result_d   = result_q;
    done_d     = 1'b0;
`ifdef FACTORIAL_OVERFLOW_EN
    ovf_d      = ovf_q;
    overflow_d = overflow_q;
`endif

    case (state_q)
      IDLE: begin
        if (start) begin
          counter_d = operand;
          acc_d     = RES_W'(1);
`ifdef FACTORIAL_OVERFLOW_EN
          ovf_d     = 1'b0;
`endif
          state_d   = MUL;
        end
      end

      MUL: begin
        // abort wins over completion so a cancelled run never publishes.
        if (abort) begin
          state_d = IDLE;
        end else if (counter_q <= N_W'(1)) begin
          // 0 and 1 both land here immediately, leaving acc = 1.
          state_d = DONE;
        end else begin
          acc_d     = w_prod_lo;
          counter_d = counter_q - N_W'(1);
`ifdef FACTORIAL_OVERFLOW_EN
          ovf_d     = ovf_q | w_prod_hi_nz;
`endif
        end
      end

      DONE: begin
`ifdef FACTORIAL_OVERFLOW_EN
        result_d   = ovf_q ? '1 : acc_q;
        overflow_d = ovf_q;
`else
        result_d   = acc_q;
`endif
        done_d     = 1'b1;
        state_d    = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign busy        = (state_q == MUL);
  assign done        = done_q;
  assign result      = result_q;
  assign counter_out = counter_q;

`ifdef FACTORIAL_OVERFLOW_EN
  assign overflow    = overflow_q;
`else
  assign overflow    = 1'b0;
`endif

endmodule : factorial_unit
`default_nettype wire

// File: tb/tb_factorial_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_factorial_unit
//  Description : Directed self-checking bench for factorial_unit with default
//                widths (N_W=4, RES_W=16). Expected values are hand-computed;
//                the n=9 expectations follow FACTORIAL_OVERFLOW_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_factorial_unit;

  logic        clock;
  logic        reset_n;
  logic        start;
  logic        abort;
  logic [3:0]  operand;
  logic        busy;
  logic        done;
  logic [15:0] result;
  logic        overflow;
  logic [3:0]  counter_out;

  int n_tests;
  int n_fail;

  factorial_unit dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .start       (start),
    .abort       (abort),
    .operand     (operand),
    .busy        (busy),
    .done        (done),
    .result      (result),
    .overflow    (overflow),
    .counter_out (counter_out)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

`ifdef FACTORIAL_OVERFLOW_EN
  localparam logic [15:0] c_RES9 = 16'hFFFF;
  localparam logic        c_OVF9 = 1'b1;
`else
  localparam logic [15:0] c_RES9 = 16'h8980;
  localparam logic        c_OVF9 = 1'b0;
`endif

  task automatic step();
    @(negedge clock);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Pulse start for one edge; returns at the negedge after the accept edge.
  task automatic start_op(input int n);
    start   = 1'b1;
    operand = 4'(n);
    step();
    start   = 1'b0;
  endtask

  // Waits (bounded) for done; lat counts edges after the accept edge.
  task automatic wait_done(output int lat);
    int k;
    bit seen;
    k    = 0;
    seen = 1'b0;
    lat  = -1;
    while (!seen && k < 40) begin
      step();
      k++;
      if (done === 1'b1) begin
        seen = 1'b1;
        lat  = k;
      end
    end
  endtask

  task automatic run_op(input string tag, input int n, input int exp_lat,
                        input logic [15:0] exp_res, input logic exp_ovf);
    int lat;
    start_op(n);
    wait_done(lat);
    check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    check({tag, "_result"}, 32'(result), 32'(exp_res));
    check({tag, "_overflow"}, 32'(overflow), 32'(exp_ovf));
    step();
    check({tag, "_done_one_cycle"}, 32'(done), 32'd0);
  endtask

  initial begin
    int lat;
    int n_done;
    int k;

    n_tests = 0;
    n_fail  = 0;
    reset_n = 1'b0;
    start   = 1'b0;
    abort   = 1'b0;
    operand = 4'd0;

    // ---------------- reset state ----------------
    step();
    step();
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_result", 32'(result), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    check("rst_counter", 32'(counter_out), 32'd0);
    reset_n = 1'b1;
    step();

    // ---------------- n=5 with counter trace ----------------
    start_op(5);
    check("n5_busy", 32'(busy), 32'd1);
    check("n5_cnt5", 32'(counter_out), 32'd5);
    step(); check("n5_cnt4", 32'(counter_out), 32'd4);
    step(); check("n5_cnt3", 32'(counter_out), 32'd3);
    step(); check("n5_cnt2", 32'(counter_out), 32'd2);
    step(); check("n5_cnt1", 32'(counter_out), 32'd1);
    check("n5_result_stable", 32'(result), 32'd0);
    step();
    check("n5_busy_in_done", 32'(busy), 32'd0);
    check("n5_no_early_done", 32'(done), 32'd0);
    step();
    check("n5_done_at_6", 32'(done), 32'd1);
    check("n5_result", 32'(result), 32'd120);
    check("n5_overflow", 32'(overflow), 32'd0);
    step();
    check("n5_done_pulse", 32'(done), 32'd0);
    check("n5_result_hold", 32'(result), 32'd120);

    // ---------------- edge operands ----------------
    run_op("n0", 0, 2, 16'd1, 1'b0);
    run_op("n1", 1, 2, 16'd1, 1'b0);

    // ---------------- width boundary ----------------
    run_op("n8", 8, 9, 16'h9D80, 1'b0);
    run_op("n9", 9, 10, c_RES9, c_OVF9);

    // ---------------- abort on 3rd MUL cycle ----------------
    start_op(6);           // MUL cycle 1
    step();                // MUL cycle 2
    step();                // MUL cycle 3
    check("abort_busy_before", 32'(busy), 32'd1);
    abort = 1'b1;
    step();
    abort = 1'b0;
    check("abort_busy_after", 32'(busy), 32'd0);
    check("abort_no_done", 32'(done), 32'd0);
    check("abort_result_kept", 32'(result), 32'(c_RES9));
    run_op("after_abort_n3", 3, 4, 16'd6, 1'b0);

    // ---------------- start held through an n=4 run ----------------
    start   = 1'b1;
    operand = 4'd4;
    step();
    operand = 4'd9;        // must be ignored while not in IDLE
    n_done  = 0;
    lat     = -1;
    k       = 0;
    while (n_done == 0 && k < 40) begin
      step();
      k++;
      if (done === 1'b1) begin
        n_done++;
        lat = k;
      end
    end
    start = 1'b0;
    check("held_latency", 32'(lat), 32'd5);
    check("held_result", 32'(result), 32'd24);
    step();
    check("held_no_requeue_busy", 32'(busy), 32'd0);
    check("held_no_second_done", 32'(done), 32'd0);

    // ---------------- reset mid-computation ----------------
    start_op(7);
    step();
    step();
    check("rstmid_busy_before", 32'(busy), 32'd1);
    #1 reset_n = 1'b0;
    #1;
    check("rstmid_busy", 32'(busy), 32'd0);
    check("rstmid_done", 32'(done), 32'd0);
    check("rstmid_result", 32'(result), 32'd0);
    check("rstmid_overflow", 32'(overflow), 32'd0);
    check("rstmid_counter", 32'(counter_out), 32'd0);
    step();
    step();
    reset_n = 1'b1;
    n_done  = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (done === 1'b1) n_done++;
    end
    check("rstmid_no_done_after", 32'(n_done), 32'd0);
    check("rstmid_result_after", 32'(result), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_factorial_unit
`default_nettype wire

// File: doc/factorial_unit.md
# factorial_unit

Parametrised iterative factorial engine, successor to the single-width decrement/multiply datapath. It accepts an operand n on a start handshake, computes n! through a decrementing counter and a multiply-accumulate register under FSM control, and reports the result with a done pulse. Operand and result widths are generic, and an optional overflow/saturation path is included. The block sits between the memory read port, which supplies n, and the result bus.

## Interface
- `N_W`, default 4: operand/counter width.
- `RES_W`, default 16: accumulator/result width; must be ≥ `N_W`.

- `clock`  in  1  system clock, rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  request; sampled only in IDLE.
- `abort`  in  1  cancel the computation in progress; effective in MUL only.
- `operand`  in  `N_W`  n; captured when `start` is accepted.
- `busy`  out  1  high in MUL.
- `done`  out  1  one-cycle pulse when `result` is updated.
- `result`  out  `RES_W`  last completed n!; holds until the next completion.
- `overflow`  out  1  overflow flag for the last completed result. Tied to 0 when the overflow feature is compiled out.
- `counter_out`  out  `N_W`  live counter value, for debug.

## Operation
- Reset values: state IDLE, `counter`=0, accumulator=1, `result`=0, `busy`=0, `done`=0, `overflow`=0.
- States: IDLE, MUL, DONE.
- **IDLE**
  - If `start`=1: `counter`←`operand`, accumulator←1, internal ovf←0, next state MUL.
  - Otherwise remain in IDLE.
- **MUL**, evaluated in this priority order:
  - `abort`=1: next state IDLE. `result`, `overflow` and `done` are untouched.
  - `counter`≤1: next state DONE.
  - Otherwise: accumulator←low `RES_W` bits of (accumulator×`counter`), `counter`←`counter`−1.
- **DONE**
  - `result`←accumulator, `overflow`←internal ovf, `done`=1, next state IDLE.
- `start` is ignored outside IDLE. No queueing: a `start` seen in MUL or DONE is dropped.
- Arithmetic:
  - The product is `RES_W`+`N_W` bits wide.
  - The accumulator keeps the low `RES_W` bits.
  - The counter decrement never goes below 1, because the state exits at `counter`≤1.
- Edge operands:
  - 0! = 1! = 1, with no multiply performed.
  - n = 2^`N_W`−1 is legal.

## Timing
- Start accepted on edge E0.
- `done` is high for exactly the cycle after edge E0+max(n,1)+1.
  - Latency is max(n,1)+1 cycles.
  - Examples: n=5 → 6 cycles; n=0 → 2 cycles.
- `result`/`overflow` change only on the DONE edge and are stable otherwise.
- `busy` is high from E0+1 until the DONE state is entered; it is low during the `done` cycle.
- Back-to-back operation: the earliest next `start` is accepted in the cycle after `done`, because IDLE is re-entered then.
- `abort` takes effect at the next edge. `busy` drops one cycle later.
- `reset_n` asserted mid-computation: all state returns to reset values immediately (asynchronous), and no `done` is generated.

## Configuration
- Macro `FACTORIAL_OVERFLOW_EN`.
- **Defined:**
  - Internal ovf is set sticky whenever the upper `N_W` product bits are non-zero during a MUL step.
  - When ovf is set at DONE, `result` is saturated to all ones and `overflow`=1.
- **Undefined:**
  - No detection logic is built.
  - `result` is the truncated low `RES_W` bits.
  - `overflow` is constant 0.

## Structure
- Package `factorial_pkg` holds:
  - state enum typedef `fact_state_t` {IDLE, MUL, DONE};
  - default width constants `FACT_N_W`=4 and `FACT_RES_W`=16.
- Sub-module `fact_mul`: parametrised `RES_W`×`N_W` multiplier. It outputs the truncated product plus a high-bits-nonzero flag. The flag output exists only under `FACTORIAL_OVERFLOW_EN`.
- FSM, counter and registers stay in `factorial_unit`.

## Test plan
- Reset, then n=5 with defaults → `done` pulse 6 cycles after start, `result`=120, `overflow`=0; `counter_out` steps 5,4,3,2,1.
- n=0 and n=1 → `done` after 2 cycles, `result`=1 in both cases.
- n=8 → `result`=40320 (0x9D80), no overflow. Then n=9:
  - with macro: `result`=0xFFFF, `overflow`=1;
  - without macro: `result`=0x8980 (362880 mod 65536), `overflow`=0.
- Start n=6, pulse `abort` on the 3rd MUL cycle → no `done`, `result` keeps its previous value. A new start of n=3 the next cycle → `result`=6.
- Assert `start` throughout a n=4 run and drive `reset_n` low mid-MUL in a second run:
  - the first run yields exactly one `done` with `result`=24;
  - the reset run leaves all outputs at their reset values.
